// File: rtl/osc_pkg.sv
// Shared codes and constants for the poly_oscillator datapath.
package osc_pkg;

  // Waveform codes held in each voice's wave register (5-15 behave as off).
  localparam logic [3:0] WaveOff    = 4'd0;
  localparam logic [3:0] WaveSaw    = 4'd1;
  localparam logic [3:0] WaveSquare = 4'd2;
  localparam logic [3:0] WaveTri    = 4'd3;
  localparam logic [3:0] WaveNoise  = 4'd4;

  // Config port register selects (3 is ignored).
  localparam logic [1:0] CfgInc      = 2'd0;
  localparam logic [1:0] CfgWave     = 2'd1;
  localparam logic [1:0] CfgPhaseRst = 2'd2;

  localparam logic [15:0] LfsrMask = 16'hB400;
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrMask : 16'h0000);
  endfunction

endpackage

// File: rtl/osc_shaper.sv
// Combinational waveform shaper: updated phase top bits + wave code -> voice sample.
module osc_shaper
  import osc_pkg::*;
#(
  parameter int unsigned BitDepth = 12
) (
  // Top BitDepth+1 bits of the phase: MSB plus the BitDepth bits below it.
  input  logic [BitDepth:0]   phase_i,
  input  logic [3:0]          wave_i,
  input  logic [BitDepth-1:0] noise_i,
  output logic [BitDepth-1:0] shaped_o
);

  // Select the waveform; unknown codes fall back to the mid-scale "off" level.
  always_comb begin
    shaped_o = '0;
    shaped_o[BitDepth-1] = 1'b1;
    case (wave_i)
      WaveSaw:    shaped_o = phase_i[BitDepth:1];
      WaveSquare: shaped_o = phase_i[BitDepth] ? '0 : '1;
      WaveTri:    shaped_o = phase_i[BitDepth-1:0] ^ {BitDepth{phase_i[BitDepth]}};
      WaveNoise:  shaped_o = noise_i;
      default:    ;
    endcase
  end

endmodule

// File: rtl/poly_oscillator.sv
// Time-multiplexed multi-voice oscillator: one phase datapath scans all voices per
// sample tick, sums the shaped voices and strobes the mixed sample out.
module poly_oscillator
  import osc_pkg::*;
#(
  parameter int unsigned Voices      = 4,
  parameter int unsigned BitDepth    = 12,
  parameter int unsigned BitFraction = 12,
  localparam int unsigned AccW = BitDepth + BitFraction,
  localparam int unsigned VW   = (Voices > 1) ? $clog2(Voices) : 1,
  localparam int unsigned OutW = BitDepth + $clog2(Voices)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            sample_tick_i,
  input  logic            cfg_we_i,
  input  logic [VW-1:0]   cfg_voice_i,
  input  logic [1:0]      cfg_addr_i,
  input  logic [15:0]     cfg_wdata_i,
  output logic [OutW-1:0] out_o,
  output logic            out_valid_o,
  output logic            overrun_o
);

  state_e              state_q, state_d;
  logic [VW-1:0]       slot_q, slot_d;
  logic [AccW-1:0]     phase_q [Voices];
  logic [AccW-1:0]     phase_d [Voices];
  logic [15:0]         inc_q   [Voices];
  logic [15:0]         inc_d   [Voices];
  logic [3:0]          wave_q  [Voices];
  logic [3:0]          wave_d  [Voices];
  logic [BitDepth-1:0] noise_q [Voices];
  logic [BitDepth-1:0] noise_d [Voices];
  logic [15:0]         lfsr_q, lfsr_d;
  logic [OutW-1:0]     acc_q, acc_d;
  logic [OutW-1:0]     out_q, out_d;

  logic [AccW:0]       sum;
  logic [AccW-1:0]     p;
  logic                noise_adv;
  logic [15:0]         lfsr_adv;
  logic [BitDepth-1:0] slot_noise;
  logic [BitDepth-1:0] shaped;

  // Slot datapath: phase add with carry, and the noise value this slot would shape.
  always_comb begin
    sum        = {1'b0, phase_q[slot_q]} + (AccW + 1)'(inc_q[slot_q]);
    p          = sum[AccW-1:0];
    lfsr_adv   = lfsr_next(lfsr_q);
    noise_adv  = (wave_q[slot_q] == WaveNoise) && sum[AccW];
    // A noise voice shapes the freshly loaded value when its phase wraps.
    slot_noise = noise_adv ? lfsr_adv[15 -: BitDepth] : noise_q[slot_q];
  end

  osc_shaper #(
    .BitDepth(BitDepth)
  ) u_shaper (
    .phase_i (p[AccW-1 -: BitDepth+1]),
    .wave_i  (wave_q[slot_q]),
    .noise_i (slot_noise),
    .shaped_o(shaped)
  );

  // Scan FSM and register-file next state; config writes are applied last so a
  // phase reset overrides a same-cycle slot update.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    acc_d   = acc_q;
    out_d   = out_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    wave_d  = wave_q;
    noise_d = noise_q;
    lfsr_d  = lfsr_q;

    unique case (state_q)
      StIdle: begin
        if (sample_tick_i) begin
          state_d = StScan;
          slot_d  = '0;
          acc_d   = '0;
        end
      end
      StScan: begin
        phase_d[slot_q] = p;
        acc_d = acc_q + OutW'(shaped);
        if (noise_adv) begin
          lfsr_d          = lfsr_adv;
          noise_d[slot_q] = slot_noise;
        end
        if (slot_q == VW'(Voices - 1)) begin
          state_d = StDone;
          // Load the final sum now so out is already new while out_valid is high.
          out_d   = acc_d;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (cfg_we_i && (32'(cfg_voice_i) < Voices)) begin
      case (cfg_addr_i)
        CfgInc:      inc_d[cfg_voice_i]   = cfg_wdata_i;
        CfgWave:     wave_d[cfg_voice_i]  = cfg_wdata_i[3:0];
        CfgPhaseRst: phase_d[cfg_voice_i] = '0;
        default:     ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      slot_q  <= '0;
      lfsr_q  <= LfsrSeed;
      acc_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < int'(Voices); i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        wave_q[i]  <= WaveOff;
        noise_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      lfsr_q  <= lfsr_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      wave_q  <= wave_d;
      noise_q <= noise_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = (state_q == StDone);
  assign overrun_o   = sample_tick_i && (state_q != StIdle);

endmodule

// File: doc/poly_oscillator.md
# poly_oscillator

Time-multiplexed multi-voice oscillator for the audio subsystem. One shared phase-accumulator datapath scans all voices on each sample tick, shapes each voice into saw, square, triangle or noise, sums them, and presents one mixed sample with a valid strobe to the downstream mixer/PWM stage. It runs in the system clock domain and treats the sample rate as a one-cycle tick, not as a clock. Per-voice increment, waveform and phase-reset are set through a small register-write port.

## Interface
- VOICES, 4, number of voices (≥1)
- BITDEPTH, 12, per-voice sample width
- BITFRACTION, 12, phase fraction bits; ACCW = BITDEPTH+BITFRACTION, must be ≥16
- VW (derived), max(1,$clog2(VOICES)), voice index width
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- sample_tick  in  1  one-cycle strobe starting a scan
- cfg_we  in  1  config write strobe
- cfg_voice  in  VW  target voice
- cfg_addr  in  2  0=increment, 1=waveform, 2=phase reset, 3=ignored
- cfg_wdata  in  16  write data (increment; waveform in [3:0])
- out  out  BITDEPTH+$clog2(VOICES)  mixed sample, unsigned
- out_valid  out  1  one-cycle strobe, out updated
- overrun  out  1  one-cycle pulse, tick dropped while busy

## Operation
- Reset (rst low, async): all phases 0, increments 0, waveforms 0 (off), noise holds 0, LFSR = 16'hACE1, FSM IDLE, out=0, out_valid=0, overrun=0.
- FSM: IDLE --sample_tick--> SCAN (slot v=0..VOICES-1, one voice/cycle) --last slot--> DONE (one cycle) --> IDLE.
- Per slot: phase[v] <= (phase[v] + zero-extended increment[v]) mod 2^ACCW; shaped value uses the updated phase p.
- Waveform codes: 0 off -> 2^(BITDEPTH-1); 1 saw -> p[ACCW-1 -: BITDEPTH]; 2 square -> all-ones if p MSB=0, else 0; 3 triangle -> p[ACCW-2 -: BITDEPTH], bitwise inverted when p MSB=1; 4 noise -> held value; 5-15 treated as off.
- Noise: shared 16-bit Galois LFSR, mask 16'hB400, shifts right. It advances once in a noise voice's slot when that voice's phase add carries out. The voice's held value is then loaded from LFSR[15 -: BITDEPTH] of the new state. Otherwise the held value is unchanged.
- Mix: accumulator cleared on IDLE->SCAN; each slot adds its shaped value. In DONE, out <= accumulator and out_valid=1.
- Config writes are accepted in any state and take effect on the clock edge.
  - A slot reads register values before that edge, so a write to the voice in its own slot applies from the next tick.
  - Phase reset sets phase[v]=0. If it coincides with that voice's slot update, the reset wins (phase=0, shaped from the updated p as computed).
- sample_tick in SCAN or DONE is dropped and overrun pulses that cycle. The scan in progress is unaffected.
- sample_tick in IDLE during the same cycle as DONE->IDLE cannot occur (DONE is not IDLE). A tick arriving in DONE is dropped.

## Timing
- Tick at cycle T: slots T+1..T+VOICES, out_valid at T+VOICES+1, new out visible the same cycle.
- Minimum tick spacing: VOICES+2 cycles.
- out holds between strobes.
- Reset mid-scan aborts immediately. No out_valid follows.

## Structure
- Package osc_pkg: waveform codes (OFF, SAW, SQUARE, TRI, NOISE), cfg_addr codes, LFSR_MASK, LFSR_SEED, FSM state enum.
- Sub-module osc_shaper: combinational (p, wave, noise_hold) -> BITDEPTH value.
- Top holds FSM, register files, LFSR and accumulator.

## Test plan
(VOICES=4, BITDEPTH=12, BITFRACTION=12.)
- Reset, all voices off, one tick at T -> out=0 before T+5; out_valid only at T+5 with out=8192; overrun=0.
- Voice0 saw, inc=2^13 -> after tick k, out = (2k mod 4096)+6144, e.g. k=1 gives 6146, k=2048 gives 6144.
- Voice1 square, inc=2^21, others off -> voice1 contributes 4095 for ticks 1-3, 0 for ticks 4-7, repeating; out alternates 10239 / 6144.
- Tick re-asserted at T+2 -> overrun pulse at T+2; single out_valid at T+5; next legal tick at T+6 accepted.
- Phase-reset write to voice2 in its own slot cycle (T+3) -> phase[2]=0 afterwards; next tick's voice2 value derived from 0+inc.
- rst low at T+2 mid-scan -> out=0, out_valid never asserts for that tick, LFSR=16'hACE1; a noise voice with inc=2^15 reproduces an identical sequence after each reset.
